// File: rtl/tube_hit_timer.sv
// Per-tube drift-time front end: arms on gate_en, timestamps the first pin edge, counts hits.
// Optional glitch filter selected by defining TUBE_GLITCH_FILTER_EN.
`timescale 1ns/1ps
module tube_hit_timer #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned WINDOW      = 255,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HITS_W      = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              gate_en,
  input  logic              tube_pin,
  output logic [CNT_W-1:0]  clk_cyc_data,
  output logic              hit_valid,
  output logic [HITS_W-1:0] hit_count,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {StIdle, StArmed, StDone} state_e;

  localparam logic [CNT_W-1:0]  LastCnt = CNT_W'(WINDOW - 1);
  localparam logic [HITS_W-1:0] HitsMax = '1;

  state_e              r_state, w_state_next;
  logic [SYNC_STAGES-1:0] r_pin_sync, r_gate_sync;
  logic                r_pin_d, r_gate_d;
  logic [CNT_W-1:0]    r_cnt, w_cnt_next;
  logic [CNT_W-1:0]    r_ts, w_ts_next;
  logic                r_valid, w_valid_next;
  logic [HITS_W-1:0]   r_hits, w_hits_next;

  logic                w_pin_s, w_gate_s, w_gate_rise, w_edge;
  logic [CNT_W-1:0]    w_edge_ts;

  assign w_pin_s     = r_pin_sync[SYNC_STAGES-1];
  assign w_gate_s    = r_gate_sync[SYNC_STAGES-1];
  assign w_gate_rise = w_gate_s & ~r_gate_d;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_pin_sync  <= '0;
      r_gate_sync <= '0;
      r_pin_d     <= 1'b0;
      r_gate_d    <= 1'b0;
    end else begin
      r_pin_sync  <= {r_pin_sync[SYNC_STAGES-2:0], tube_pin};
      r_gate_sync <= {r_gate_sync[SYNC_STAGES-2:0], gate_en};
      r_pin_d     <= w_pin_s;
      r_gate_d    <= w_gate_s;
    end
  end

`ifdef TUBE_GLITCH_FILTER_EN
  localparam int unsigned FiltLen = 3;

  logic       w_raw_edge;
  logic [1:0] r_filt_run;
  logic [CNT_W-1:0] r_filt_ts;
  logic       r_filt_ok;

  assign w_raw_edge = w_pin_s & ~r_pin_d;

  // r_filt_run counts prior consecutive high cycles; the timestamp is taken at pulse start
  // and only committed once the pulse has stayed high for FiltLen cycles.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_filt_run <= '0;
      r_filt_ts  <= '0;
      r_filt_ok  <= 1'b0;
    end else begin
      if (!w_pin_s) begin
        r_filt_run <= '0;
      end else if (r_filt_run != 2'(FiltLen)) begin
        r_filt_run <= r_filt_run + 2'd1;
      end
      if (w_raw_edge) begin
        r_filt_ts <= r_cnt;
        r_filt_ok <= (r_state == StArmed);
      end
    end
  end

  assign w_edge    = w_pin_s && (r_filt_run == 2'(FiltLen - 1)) && r_filt_ok;
  assign w_edge_ts = r_filt_ts;
`else
  assign w_edge    = w_pin_s & ~r_pin_d;
  assign w_edge_ts = r_cnt;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_ts    <= '1;
      r_valid <= 1'b0;
      r_hits  <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_ts    <= w_ts_next;
      r_valid <= w_valid_next;
      r_hits  <= w_hits_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_ts_next    = r_ts;
    w_valid_next = r_valid;
    w_hits_next  = r_hits;
    unique case (r_state)
      StIdle: begin
        w_cnt_next = '0;
        if (w_gate_rise) w_state_next = StArmed;
      end
      StArmed: begin
        if (r_cnt == LastCnt) begin
          w_state_next = StDone;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
        if (w_edge) begin
          if (!r_valid) begin
            w_ts_next    = w_edge_ts;
            w_valid_next = 1'b1;
          end
          if (r_hits != HitsMax) w_hits_next = r_hits + 1'b1;
        end
      end
      StDone: begin
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign clk_cyc_data = r_ts;
  assign hit_valid    = r_valid;
  assign hit_count    = r_hits;
  assign busy         = (r_state == StArmed);
  assign done         = (r_state == StDone);

endmodule

// File: tb/tb_tube_hit_timer.sv
// Scoreboard bench for tube_hit_timer: stimulus pushes expected results, a monitor checks on done.
`timescale 1ns/1ps
module tb_tube_hit_timer;

  logic       clk = 1'b0;
  logic       clr, gate_en, tube_pin;
  logic [7:0] clk_cyc_data;
  logic       hit_valid;
  logic [3:0] hit_count;
  logic       busy, done;

  typedef struct packed {
    logic [7:0] ts;
    logic       valid;
    logic [3:0] hits;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pos      = 0;
  logic prev_done = 1'b0;

  tube_hit_timer dut (
    .clk          (clk),
    .clr          (clr),
    .gate_en      (gate_en),
    .tube_pin     (tube_pin),
    .clk_cyc_data (clk_cyc_data),
    .hit_valid    (hit_valid),
    .hit_count    (hit_count),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    pos++;
  endtask

  task automatic goto(input int n);
    while (pos < n) tick();
  endtask

  task automatic arm();
    int k = 0;
    gate_en = 1'b1;
    while (!busy && k < 20) begin
      tick();
      k++;
    end
    chk("arm_busy", busy, 1);
    pos = 0;
    gate_en = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 400) begin
      tick();
      k++;
    end
    chk("done_reached", done, 1);
    tick();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    gate_en = 1'b0;
    tube_pin = 1'b0;
    tick();
    tick();
    clr = 1'b0;
    tick();
  endtask

  // Edge-detect cycle lands on ARMED cycle c when the pin rises two cycles earlier.
  task automatic pulse(input int c);
    goto(c - 2);
    tube_pin = 1'b1;
    goto(c);
    tube_pin = 1'b0;
  endtask

  always @(negedge clk) begin
    if (done && !prev_done) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, expected no pending result");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("mon_ts", clk_cyc_data, e.ts);
        chk("mon_valid", hit_valid, e.valid);
        chk("mon_hits", hit_count, e.hits);
        chk("mon_busy", busy, 0);
      end
    end
    prev_done <= done;
  end

  initial begin
    clr = 1'b1;
    gate_en = 1'b0;
    tube_pin = 1'b0;
    for (int i = 0; i < 6; i++) begin
      gate_en  = 1'($urandom % 2);
      tube_pin = 1'($urandom % 2);
      tick();
    end
    chk("rst_ts", clk_cyc_data, 8'hFF);
    chk("rst_valid", hit_valid, 0);
    chk("rst_hits", hit_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    gate_en = 1'b0;
    tube_pin = 1'b0;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("idle_busy", busy, 0);

`ifndef TUBE_GLITCH_FILTER_EN
    // Single hit at cnt 40, window length check
    q.push_back('{ts: 8'd40, valid: 1'b1, hits: 4'd1});
    arm();
    pulse(40);
    goto(254);
    chk("last_armed_busy", busy, 1);
    chk("last_armed_done", done, 0);
    tick();
    chk("window_done", done, 1);
    chk("window_busy", busy, 0);
    tick();
    do_clr();

    // No hit
    q.push_back('{ts: 8'hFF, valid: 1'b0, hits: 4'd0});
    arm();
    wait_done();
    do_clr();
    chk("nohit_clr_busy", busy, 0);
    chk("nohit_clr_done", done, 0);
    chk("nohit_clr_ts", clk_cyc_data, 8'hFF);

    // Multi-hit with saturation
    q.push_back('{ts: 8'd10, valid: 1'b1, hits: 4'd15});
    arm();
    pulse(10);
    pulse(20);
    for (int i = 0; i < 20; i++) pulse(30 + 4 * i);
    wait_done();
    do_clr();

    // Edge on the last window cycle, then edges after DONE
    q.push_back('{ts: 8'd254, valid: 1'b1, hits: 4'd1});
    arm();
    goto(252);
    tube_pin = 1'b1;
    wait_done();
    tube_pin = 1'b0;
    tick();
    tick();
    tube_pin = 1'b1;
    tick();
    tick();
    tick();
    chk("post_done_ts", clk_cyc_data, 8'd254);
    chk("post_done_hits", hit_count, 1);
    chk("post_done_done", done, 1);
    do_clr();

    // Pin already high at arming; only the later re-rise counts
    tube_pin = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    q.push_back('{ts: 8'd72, valid: 1'b1, hits: 4'd1});
    arm();
    goto(60);
    tube_pin = 1'b0;
    goto(70);
    tube_pin = 1'b1;
    wait_done();
    do_clr();

    // clr in mid-window aborts immediately
    arm();
    pulse(20);
    goto(100);
    clr = 1'b1;
    gate_en = 1'b0;
    tube_pin = 1'b0;
    #1;
    chk("abort_ts", clk_cyc_data, 8'hFF);
    chk("abort_valid", hit_valid, 0);
    chk("abort_hits", hit_count, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    tick();
    clr = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("abort_idle", busy, 0);

    // Short and long pulse: both count without the filter
    q.push_back('{ts: 8'd30, valid: 1'b1, hits: 4'd2});
`else
    q.push_back('{ts: 8'd50, valid: 1'b1, hits: 4'd1});
`endif
    arm();
    goto(28);
    tube_pin = 1'b1;
    goto(30);
    tube_pin = 1'b0;
    goto(48);
    tube_pin = 1'b1;
    goto(53);
    tube_pin = 1'b0;
    wait_done();
    do_clr();

    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
